// File: rtl/gmii_rx_deframer_pkg.sv
// gmii_rx_deframer_pkg
//   Shared definitions for the GMII receive deframer: FSM state type,
//   preamble/SFD byte values, CRC-32 polynomial/init/residue, the depth of
//   the FCS-stripping delay line, and the end-of-frame status record.
package gmii_rx_deframer_pkg;

  typedef enum logic [1:0] {
    ST_DROP     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PREAMBLE = 2'd2,
    ST_DATA     = 2'd3
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected IEEE 802.3 polynomial; the register is not inverted on output,
  // so running it across payload + FCS leaves the fixed residue below.
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  // Four FCS bytes plus the byte being released.
  localparam int          DLY_DEPTH     = 5;

  typedef struct packed {
    logic        crc_err;
    logic        phy_err;
    logic        len_err;
    logic [15:0] len;
  } rx_status_t;

endpackage

// File: rtl/gmii_rx_deframer_crc32_d8.sv
// crc32_d8
//   Combinational byte-wide CRC-32 update (reflected, LSB first).
//   Ports:
//     crc_in  [31:0]  current CRC register
//     data    [7:0]   byte being absorbed
//     crc_out [31:0]  CRC register after absorbing data
module crc32_d8
  import gmii_rx_deframer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//   Strips preamble/SFD and FCS from a GMII receive stream, checks CRC-32,
//   length and PHY error, and emits the payload as a byte stream with
//   sof/eof framing and end-of-frame status. No backpressure.
//   Parameters:
//     MIN_LEN / MAX_LEN  legal frame length range (bytes after SFD, FCS incl.)
//   Ports:
//     clk, reset                        GMII rx clock, async active-high reset
//     gmii_rxd/gmii_rxdv/gmii_rxer      GMII receive inputs
//     rx_data/rx_valid/rx_sof/rx_eof    payload stream
//     rx_crc_err/rx_phy_err/rx_len_err  frame status, valid with rx_eof
//     rx_len                            frame length incl. FCS, saturating
//     rx_drop                           pulse when a frame is discarded unseen
//     cnt_good/cnt_bad                  wrapping frame counters
module gmii_rx_deframer
  import gmii_rx_deframer_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_err,
  output logic        rx_phy_err,
  output logic        rx_len_err,
  output logic [15:0] rx_len,
  output logic        rx_drop,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_bad
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [15:0] DLY_L = 16'(DLY_DEPTH);

  logic [7:0]  rxd_q;
  logic        rxdv_q;
  logic        rxer_q;

  rx_state_t   state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [15:0] len;
  logic        phy_err;
  logic [DLY_DEPTH-1:0][7:0] dly;   // dly[0] newest, dly[DLY_DEPTH-1] oldest
  rx_status_t  st;
  logic        frame_bad;

  // Input capture register is deliberately outside reset: it keeps tracking
  // the wire during reset, so the DROP state sees the true rxdv on the first
  // cycle after release and a frame in flight is skipped without a drop pulse.
  always_ff @(posedge clk) begin
    rxd_q  <= gmii_rxd;
    rxdv_q <= gmii_rxdv;
    rxer_q <= gmii_rxer;
  end

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (rxd_q),
    .crc_out (crc_next)
  );

  always_comb begin
    st.crc_err = (crc != CRC_RESIDUE);
    st.phy_err = phy_err;
    st.len_err = (len < MIN_L) || (len > MAX_L);
    st.len     = len;
    frame_bad  = st.crc_err | st.phy_err | st.len_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_DROP;
      crc        <= '0;
      len        <= '0;
      phy_err    <= 1'b0;
      dly        <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_phy_err <= 1'b0;
      rx_len_err <= 1'b0;
      rx_len     <= '0;
      rx_drop    <= 1'b0;
      cnt_good   <= '0;
      cnt_bad    <= '0;
    end else begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_phy_err <= 1'b0;
      rx_len_err <= 1'b0;
      rx_len     <= '0;
      rx_drop    <= 1'b0;

      case (state)
        ST_DROP: begin
          if (!rxdv_q) state <= ST_IDLE;
        end

        ST_IDLE, ST_PREAMBLE: begin
          if (!rxdv_q) begin
            state <= ST_IDLE;
          end else if (rxd_q == PREAMBLE_BYTE) begin
            state <= ST_PREAMBLE;
          end else if (rxd_q == SFD_BYTE) begin
            state   <= ST_DATA;
            crc     <= CRC_INIT;
            len     <= '0;
            phy_err <= 1'b0;
          end else begin
            state   <= ST_DROP;
            rx_drop <= 1'b1;
            cnt_bad <= cnt_bad + 32'd1;
          end
        end

        ST_DATA: begin
          if (rxdv_q) begin
            dly     <= {dly[DLY_DEPTH-2:0], rxd_q};
            crc     <= crc_next;
            len     <= (len == 16'hFFFF) ? len : len + 16'd1;
            phy_err <= phy_err | rxer_q;
            // Once the line is full, the oldest byte can no longer be FCS.
            if (len >= DLY_L) begin
              rx_valid <= 1'b1;
              rx_data  <= dly[DLY_DEPTH-1];
              rx_sof   <= (len == DLY_L);
            end
          end else begin
            state <= ST_IDLE;
            if (len >= DLY_L) begin
              // The last non-FCS byte is still the oldest entry.
              rx_valid   <= 1'b1;
              rx_data    <= dly[DLY_DEPTH-1];
              rx_sof     <= (len == DLY_L);
              rx_eof     <= 1'b1;
              rx_crc_err <= st.crc_err;
              rx_phy_err <= st.phy_err;
              rx_len_err <= st.len_err;
              rx_len     <= st.len;
              if (frame_bad) cnt_bad  <= cnt_bad + 32'd1;
              else           cnt_good <= cnt_good + 32'd1;
            end else begin
              rx_drop <= 1'b1;
              cnt_bad <= cnt_bad + 32'd1;
            end
          end
        end

        default: state <= ST_DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
module tb_gmii_rx_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rxdv;
  logic        gmii_rxer;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic        rx_crc_err, rx_phy_err, rx_len_err;
  logic [15:0] rx_len;
  logic        rx_drop;
  logic [31:0] cnt_good, cnt_bad;

  always #5 clk = ~clk;

  gmii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .clk        (clk),
    .reset      (reset),
    .gmii_rxd   (gmii_rxd),
    .gmii_rxdv  (gmii_rxdv),
    .gmii_rxer  (gmii_rxer),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .rx_crc_err (rx_crc_err),
    .rx_phy_err (rx_phy_err),
    .rx_len_err (rx_len_err),
    .rx_len     (rx_len),
    .rx_drop    (rx_drop),
    .cnt_good   (cnt_good),
    .cnt_bad    (cnt_bad)
  );

  typedef struct packed { logic sof; logic eof; logic [7:0] data; } beat_t;
  typedef struct packed { logic crc; logic phy; logic lerr; logic [15:0] len; } stat_t;

  int n_chk = 0, n_err = 0;

  beat_t obs_beats[$], exp_beats[$];
  stat_t obs_stat[$],  exp_stat[$];
  int    obs_drops = 0, exp_drops = 0;
  int    viol = 0;
  int    exp_good = 0, exp_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      obs_beats.delete();
      obs_stat.delete();
      obs_drops = 0;
    end else begin
      if (rx_valid) begin
        obs_beats.push_back({rx_sof, rx_eof, rx_data});
        if (rx_eof) obs_stat.push_back({rx_crc_err, rx_phy_err, rx_len_err, rx_len});
      end else if (rx_sof || rx_eof || rx_crc_err || rx_phy_err || rx_len_err || rx_len != 0) begin
        viol++;
      end
      if (rx_drop) obs_drops++;
    end
  end

  // Textbook bit-serial FCS: ~CRC over the bytes before the FCS.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        logic fb = c[0] ^ b[i][j];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic drive_byte(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk); #1;
    gmii_rxdv = dv; gmii_rxd = d; gmii_rxer = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_byte(1'b0, 8'($urandom), 1'($urandom));
  endtask

  // Drives one frame and records what the deframer must produce for it.
  task automatic send_frame(input int pre_n, input bit bad_pre, input int len,
                            input bit good_fcs, input int flip_bit, input int er_idx,
                            input int gap);
    logic [7:0] f[$];
    logic [31:0] fcs;
    logic [7:0] tmp;
    bit crc_bad, phy, lerr;
    if (bad_pre) begin
      repeat (pre_n) drive_byte(1'b1, 8'h55, 1'b0);
      drive_byte(1'b1, 8'h12, 1'b0);
      repeat (3) drive_byte(1'b1, 8'($urandom), 1'b0);
      idle(gap);
      exp_drops++; exp_bad++;
      return;
    end
    if (len >= 4) begin
      repeat (len - 4) f.push_back(8'($urandom));
      fcs = fcs_of(f, len - 4);
      if (!good_fcs) fcs = fcs ^ 32'h0000_0100;
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
    end else begin
      repeat (len) f.push_back(8'($urandom));
    end
    if (flip_bit >= 0) begin
      tmp = f[flip_bit / 8];
      tmp[flip_bit % 8] = ~tmp[flip_bit % 8];
      f[flip_bit / 8] = tmp;
    end
    repeat (pre_n) drive_byte(1'b1, 8'h55, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) drive_byte(1'b1, f[i], (i == er_idx));
    idle(gap);

    if (len <= 4) begin
      exp_drops++; exp_bad++;
    end else begin
      for (int i = 0; i <= len - 5; i++)
        exp_beats.push_back({(i == 0), (i == len - 5), f[i]});
      fcs     = fcs_of(f, len - 4);
      crc_bad = (fcs != {f[len-1], f[len-2], f[len-3], f[len-4]});
      phy     = (er_idx >= 0) && (er_idx < len);
      lerr    = (len < 64) || (len > 1522);
      exp_stat.push_back({crc_bad, phy, lerr, 16'(len)});
      if (crc_bad || phy || lerr) exp_bad++; else exp_good++;
    end
  endtask

  task automatic compare_batch(input string name);
    int n;
    idle(6);
    chk($sformatf("%s beat_count", name), obs_beats.size(), exp_beats.size());
    n = (obs_beats.size() < exp_beats.size()) ? obs_beats.size() : exp_beats.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s beat[%0d]", name, i), 32'(obs_beats[i]), 32'(exp_beats[i]));
    chk($sformatf("%s eof_count", name), obs_stat.size(), exp_stat.size());
    n = (obs_stat.size() < exp_stat.size()) ? obs_stat.size() : exp_stat.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s status[%0d]", name, i), 32'(obs_stat[i]), 32'(exp_stat[i]));
    chk($sformatf("%s drops", name), obs_drops, exp_drops);
    chk($sformatf("%s cnt_good", name), cnt_good, exp_good);
    chk($sformatf("%s cnt_bad", name), cnt_bad, exp_bad);
    chk($sformatf("%s idle_fields_zero", name), viol, 0);
    obs_beats.delete(); exp_beats.delete();
    obs_stat.delete();  exp_stat.delete();
  endtask

  initial begin
    int len, er;
    reset = 1'b1; gmii_rxd = 8'h00; gmii_rxdv = 1'b0; gmii_rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_drop", rx_drop, 0);
    chk("reset rx_len", rx_len, 0);
    chk("reset cnt_good", cnt_good, 0);
    chk("reset cnt_bad", cnt_bad, 0);
    reset = 1'b0;
    idle(3);

    send_frame(7, 0, 64, 1, -1, -1, 4);
    compare_batch("good64");

    send_frame(7, 0, 64, 1, 8*10+3, -1, 4);
    compare_batch("bitflip64");

    send_frame(2, 1, 0, 1, -1, -1, 3);
    send_frame(7, 0, 64, 1, -1, -1, 3);
    compare_batch("badpre");

    send_frame(7, 0, 100, 1, -1, 20, 3);
    send_frame(7, 0, 3, 1, -1, -1, 3);
    compare_batch("rxer_short");

    send_frame(7, 0, 64, 1, -1, -1, 1);
    send_frame(7, 0, 64, 1, -1, -1, 1);
    send_frame(7, 0, 1600, 1, -1, -1, 3);
    compare_batch("b2b_long");

    send_frame(0, 0, 5, 1, -1, -1, 1);
    send_frame(1, 0, 4, 1, -1, -1, 1);
    send_frame(3, 0, 0, 1, -1, -1, 1);
    send_frame(0, 1, 0, 1, -1, -1, 1);
    send_frame(7, 0, 6, 0, -1, -1, 1);
    send_frame(7, 0, 1522, 1, -1, -1, 2);
    send_frame(7, 0, 1523, 1, -1, -1, 2);
    send_frame(7, 0, 63, 1, -1, -1, 2);
    compare_batch("edges");

    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 10; k++) begin
        len = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 6) : $urandom_range(20, 200);
        er  = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
        send_frame($urandom_range(0, 7), ($urandom_range(0, 99) < 8), len,
                   ($urandom_range(0, 4) != 0), -1, er, $urandom_range(1, 3));
      end
      compare_batch($sformatf("rand%0d", b));
    end

    // Reset in the middle of a frame that is already streaming out.
    repeat (7) drive_byte(1'b1, 8'h55, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive_byte(1'b1, 8'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst rx_valid", rx_valid, 0);
    chk("midrst rx_data", rx_data, 0);
    chk("midrst cnt_good", cnt_good, 0);
    chk("midrst cnt_bad", cnt_bad, 0);
    for (int i = 30; i < 32; i++) drive_byte(1'b1, 8'($urandom), 1'b0);
    reset = 1'b0;
    for (int i = 32; i < 80; i++) drive_byte(1'b1, 8'($urandom), 1'b0);
    idle(2);
    exp_good = 0; exp_bad = 0; exp_drops = 0;
    exp_beats.delete(); exp_stat.delete();
    compare_batch("midrst");

    send_frame(7, 0, 64, 1, -1, -1, 3);
    compare_batch("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
